// File: rtl/port_tx.sv
// Ingress transmitter for one switch port: buffers source words in a small FIFO
// and offers them to the switch one at a time, counting acks and timed-out drops.
module port_tx #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned AF_THROTTLE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [DATA_W-1:0] src_data,
   input  logic [ADDR_W-1:0] src_addr,
   output logic [DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0] addr_in,
   output logic              wr_en,
   input  logic              data_rcv,
   input  logic              fifo_full,
   input  logic              fifo_af,
   output logic [15:0]       sent_cnt,
   output logic [7:0]        drop_cnt,
   output logic              timeout_err,
   output logic              busy
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned TMR_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_mem_q [DEPTH];
   logic [DATA_W-1:0]   data_mem_d [DEPTH];
   logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
   logic [ADDR_W-1:0]   addr_mem_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [DATA_W-1:0]   data_in_q, data_in_d;
   logic [ADDR_W-1:0]   addr_in_q, addr_in_d;
   logic                wr_en_q, wr_en_d;
   logic [15:0]         sent_cnt_q, sent_cnt_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;
   logic                timeout_err_q, timeout_err_d;
   logic                push, pop, launch_ok;

   // Held low during reset so the source cannot hand over a word that would be lost.
   assign src_ready   = reset && (count_q < CNT_W'(DEPTH));
   assign busy        = (state_q != IDLE) || (count_q != '0);
   assign data_in     = data_in_q;
   assign addr_in     = addr_in_q;
   assign wr_en       = wr_en_q;
   assign sent_cnt    = sent_cnt_q;
   assign drop_cnt    = drop_cnt_q;
   assign timeout_err = timeout_err_q;

   assign push      = src_valid && src_ready;
   assign launch_ok = (count_q != '0) && !fifo_full && !((AF_THROTTLE != 0) && fifo_af);

   always_comb begin
      state_d       = state_q;
      data_mem_d    = data_mem_q;
      addr_mem_d    = addr_mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      timer_d       = timer_q;
      data_in_d     = data_in_q;
      addr_in_d     = addr_in_q;
      wr_en_d       = wr_en_q;
      sent_cnt_d    = sent_cnt_q;
      drop_cnt_d    = drop_cnt_q;
      timeout_err_d = 1'b0;
      pop           = 1'b0;

      case (state_q)
         IDLE: begin
            if (launch_ok) begin
               pop       = 1'b1;
               data_in_d = data_mem_q[rd_ptr_q];
               addr_in_d = addr_mem_q[rd_ptr_q];
               wr_en_d   = 1'b1;
               timer_d   = '0;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (data_rcv) begin
               sent_cnt_d = sent_cnt_q + 16'd1;
               wr_en_d    = 1'b0;
               state_d    = GAP;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
               timeout_err_d = 1'b1;
               wr_en_d       = 1'b0;
               state_d       = GAP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (push) begin
         data_mem_d[wr_ptr_q] = src_data;
         addr_mem_d[wr_ptr_q] = src_addr;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_mem_q[i] <= '0;
            addr_mem_q[i] <= '0;
         end
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         timer_q       <= '0;
         data_in_q     <= '0;
         addr_in_q     <= '0;
         wr_en_q       <= 1'b0;
         sent_cnt_q    <= '0;
         drop_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         data_mem_q    <= data_mem_d;
         addr_mem_q    <= addr_mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         timer_q       <= timer_d;
         data_in_q     <= data_in_d;
         addr_in_q     <= addr_in_d;
         wr_en_q       <= wr_en_d;
         sent_cnt_q    <= sent_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_port_tx.sv
// Directed bench for port_tx: a vector table for queueing/ack/throttle behaviour,
// then hand-written timeout, drop saturation and asynchronous reset sequences.
module tb_port_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [15:0] src_data = '0;
   logic [15:0] src_addr = '0;
   logic [15:0] data_in;
   logic [15:0] addr_in;
   logic        wr_en;
   logic        data_rcv = 1'b0;
   logic        fifo_full = 1'b0;
   logic        fifo_af = 1'b0;
   logic [15:0] sent_cnt;
   logic [7:0]  drop_cnt;
   logic        timeout_err;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   port_tx #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .TIMEOUT(16), .AF_THROTTLE(1)) dut (
      .clk(clk), .reset(reset),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_addr(src_addr),
      .data_in(data_in), .addr_in(addr_in), .wr_en(wr_en),
      .data_rcv(data_rcv), .fifo_full(fifo_full), .fifo_af(fifo_af),
      .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic [15:0] a;
      logic        rcv;
      logic        full;
      logic        af;
      logic        ew;
      logic [15:0] ed;
      logic [15:0] ea;
      logic        er;
      logic [15:0] es;
      logic        eb;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic v, input logic [15:0] d, input logic [15:0] a,
                      input logic rcv, input logic full, input logic af,
                      input logic ew, input logic [15:0] ed, input logic [15:0] ea,
                      input logic er, input logic [15:0] es, input logic eb);
      vec_t t;
      t.v = v; t.d = d; t.a = a; t.rcv = rcv; t.full = full; t.af = af;
      t.ew = ew; t.ed = ed; t.ea = ea; t.er = er; t.es = es; t.eb = eb;
      vq.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int high;
      int pulses;
      int cyc;
      int n;

      // single word, queue fill with backpressure, gap/idle ack ignoring, af throttle
      add(1,16'hA5A5,16'h0002, 0,0,0, 0,16'h0000,16'h0000, 1, 0, 1);
      add(0,16'h0000,16'h0000, 0,0,0, 1,16'hA5A5,16'h0002, 1, 0, 1);
      add(0,16'h0000,16'h0000, 0,0,0, 1,16'hA5A5,16'h0002, 1, 0, 1);
      add(0,16'h0000,16'h0000, 0,0,0, 1,16'hA5A5,16'h0002, 1, 0, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 0,16'hA5A5,16'h0002, 1, 1, 1);
      add(0,16'h0000,16'h0000, 0,0,0, 0,16'hA5A5,16'h0002, 1, 1, 0);
      add(1,16'h1111,16'h0001, 0,1,0, 0,16'hA5A5,16'h0002, 1, 1, 1);
      add(1,16'h2222,16'h0002, 0,1,0, 0,16'hA5A5,16'h0002, 1, 1, 1);
      add(1,16'h3333,16'h0003, 0,1,0, 0,16'hA5A5,16'h0002, 1, 1, 1);
      add(1,16'h4444,16'h0004, 0,1,0, 0,16'hA5A5,16'h0002, 0, 1, 1);
      add(1,16'h5555,16'h0005, 0,1,0, 0,16'hA5A5,16'h0002, 0, 1, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 1,16'h1111,16'h0001, 1, 1, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 0,16'h1111,16'h0001, 1, 2, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 0,16'h1111,16'h0001, 1, 2, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 1,16'h2222,16'h0002, 1, 2, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 0,16'h2222,16'h0002, 1, 3, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 0,16'h2222,16'h0002, 1, 3, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 1,16'h3333,16'h0003, 1, 3, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 0,16'h3333,16'h0003, 1, 4, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 0,16'h3333,16'h0003, 1, 4, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 1,16'h4444,16'h0004, 1, 4, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 0,16'h4444,16'h0004, 1, 5, 1);
      add(0,16'h0000,16'h0000, 1,0,0, 0,16'h4444,16'h0004, 1, 5, 0);
      add(1,16'h6666,16'h0006, 0,0,1, 0,16'h4444,16'h0004, 1, 5, 1);
      add(0,16'h0000,16'h0000, 0,0,1, 0,16'h4444,16'h0004, 1, 5, 1);
      add(0,16'h0000,16'h0000, 0,0,1, 0,16'h4444,16'h0004, 1, 5, 1);
      add(0,16'h0000,16'h0000, 0,0,0, 1,16'h6666,16'h0006, 1, 5, 1);
      add(0,16'h0000,16'h0000, 0,0,1, 1,16'h6666,16'h0006, 1, 5, 1);
      add(0,16'h0000,16'h0000, 0,1,1, 1,16'h6666,16'h0006, 1, 5, 1);
      add(0,16'h0000,16'h0000, 1,0,1, 0,16'h6666,16'h0006, 1, 6, 1);
      add(0,16'h0000,16'h0000, 0,0,0, 0,16'h6666,16'h0006, 1, 6, 0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_src_ready", 32'(src_ready), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sent", 32'(sent_cnt), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_data_in", 32'(data_in), 32'd0);
      chk("rst_addr_in", 32'(addr_in), 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);
      reset = 1'b1;
      #1;
      chk("post_rst_ready", 32'(src_ready), 32'd1);

      foreach (vq[i]) begin
         src_valid = vq[i].v;
         src_data  = vq[i].d;
         src_addr  = vq[i].a;
         data_rcv  = vq[i].rcv;
         fifo_full = vq[i].full;
         fifo_af   = vq[i].af;
         step();
         chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vq[i].ew));
         chk($sformatf("v%0d_data_in", i), 32'(data_in), 32'(vq[i].ed));
         chk($sformatf("v%0d_addr_in", i), 32'(addr_in), 32'(vq[i].ea));
         chk($sformatf("v%0d_src_ready", i), 32'(src_ready), 32'(vq[i].er));
         chk($sformatf("v%0d_sent", i), 32'(sent_cnt), 32'(vq[i].es));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].eb));
      end
      src_valid = 0; data_rcv = 0; fifo_full = 0; fifo_af = 0;

      // timeout: never acked, wr_en high 16 cycles; second word follows after GAP
      src_valid = 1; src_data = 16'h7777; src_addr = 16'h0007;
      step();
      src_data = 16'h8888; src_addr = 16'h0008;
      step();
      src_valid = 0;
      chk("tmo_launch", 32'(wr_en), 32'd1);
      high = wr_en ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (wr_en) high++;
         else break;
      end
      chk("tmo_high_cycles", 32'(high), 32'd16);
      chk("tmo_pulse", 32'(timeout_err), 32'd1);
      chk("tmo_drop1", 32'(drop_cnt), 32'd1);
      chk("tmo_sent_same", 32'(sent_cnt), 32'd6);
      step();
      chk("tmo_pulse_end", 32'(timeout_err), 32'd0);
      chk("tmo_gap_wr_en", 32'(wr_en), 32'd0);
      step();
      chk("tmo_next_launch", 32'(wr_en), 32'd1);
      chk("tmo_next_data", 32'(data_in), 32'h8888);
      data_rcv = 1;
      step();
      data_rcv = 0;
      chk("tmo_next_ack", 32'(sent_cnt), 32'd7);
      step();

      // drop counter saturation: 299 more timeouts (300 in total)
      src_valid = 1; src_data = 16'h9999; src_addr = 16'h0009;
      pulses = 0;
      cyc = 0;
      while (pulses < 299 && cyc < 8000) begin
         step();
         cyc++;
         if (timeout_err) pulses++;
      end
      chk("sat_pulses", 32'(pulses), 32'd299);
      chk("sat_drop", 32'(drop_cnt), 32'd255);
      chk("sat_sent", 32'(sent_cnt), 32'd7);
      src_valid = 0;

      // asynchronous reset while a word is on offer
      n = 0;
      while (!wr_en && n < 40) begin
         step();
         n++;
      end
      chk("rst_mid_send_pre", 32'(wr_en), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_wr_en", 32'(wr_en), 32'd0);
      chk("arst_sent", 32'(sent_cnt), 32'd0);
      chk("arst_drop", 32'(drop_cnt), 32'd0);
      chk("arst_tmo", 32'(timeout_err), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(src_ready), 32'd0);
      chk("arst_data_in", 32'(data_in), 32'd0);
      step();
      step();
      chk("arst_hold_ready", 32'(src_ready), 32'd0);
      reset = 1'b1;
      #1;
      chk("arst_rel_ready", 32'(src_ready), 32'd1);
      repeat (3) step();
      chk("arst_q_empty_wr", 32'(wr_en), 32'd0);
      chk("arst_q_empty_busy", 32'(busy), 32'd0);
      chk("arst_drop_quiet", 32'(drop_cnt), 32'd0);
      src_valid = 1; src_data = 16'h1234; src_addr = 16'h0003;
      step();
      src_valid = 0;
      step();
      chk("arst_resume_wr", 32'(wr_en), 32'd1);
      chk("arst_resume_data", 32'(data_in), 32'h1234);
      chk("arst_resume_addr", 32'(addr_in), 32'h0003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
